// File: rtl/pipelined_adder_pkg.sv
// Shared sizing helpers for the pipelined adder tree.
package pipelined_adder_pkg;

  // Number of terms held by tree level k: ceil(amount / 2^k).
  function automatic int terms_at_level(input int amount, input int k);
    return (amount + (1 << k) - 1) >> k;
  endfunction

  // Result width: each tree level adds one bit of growth.
  function automatic int out_width(input int amount, input int width);
    return width + $clog2(amount);
  endfunction

endpackage

// File: rtl/pipelined_adder_if.sv
// Valid/ready stream bundle for the adder: operand vector in, sum out.
interface pipelined_adder_if
  import pipelined_adder_pkg::*;
#(
  parameter int NUMBERS_AMOUNT = 8,
  parameter int NUMBER_WIDTH   = 4
) ();
  localparam int OUT_WIDTH = out_width(NUMBERS_AMOUNT, NUMBER_WIDTH);

  logic [NUMBERS_AMOUNT-1:0][NUMBER_WIDTH-1:0] data_i;
  logic                                        data_valid_i;
  logic                                        ready_o;
  logic [OUT_WIDTH-1:0]                        data_o;
  logic                                        data_valid_o;
  logic                                        ready_i;

  // The adder side.
  modport slave (
    input  data_i, data_valid_i, ready_i,
    output ready_o, data_o, data_valid_o
  );

  // The environment side: upstream producer and downstream consumer.
  modport master (
    output data_i, data_valid_i, ready_i,
    input  ready_o, data_o, data_valid_o
  );
endinterface

// File: rtl/pipelined_adder_stage.sv
// One registered level of the adder tree: pairwise sums plus the odd
// leftover term, with a valid flag and skid-free ready logic.
module pipelined_adder_stage #(
  parameter int  IN_TERMS  = 2,
  parameter int  IN_WIDTH  = 4,
  parameter bit  SIGNED    = 1'b0,
  localparam int OUT_TERMS = (IN_TERMS + 1) / 2,
  localparam int OUT_WIDTH = IN_WIDTH + 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [IN_TERMS-1:0][IN_WIDTH-1:0]   in_data,
  input  logic                                in_valid,
  output logic                                in_ready,
  output logic [OUT_TERMS-1:0][OUT_WIDTH-1:0] out_data,
  output logic                                out_valid,
  input  logic                                out_ready
);
  logic [OUT_TERMS-1:0][OUT_WIDTH-1:0] sum;
  logic                                load;

  // The level may take new data when it is empty or its content is leaving.
  assign load     = !out_valid || out_ready;
  assign in_ready = load;

  for (genvar i = 0; i < OUT_TERMS; i++) begin : g_term
    logic [OUT_WIDTH-1:0] a, b;

    if (SIGNED) begin : g_sx
      assign a = {in_data[2*i][IN_WIDTH-1], in_data[2*i]};
    end else begin : g_zx
      assign a = {1'b0, in_data[2*i]};
    end

    if (2*i + 1 < IN_TERMS) begin : g_pair
      if (SIGNED) begin : g_sx
        assign b = {in_data[2*i+1][IN_WIDTH-1], in_data[2*i+1]};
      end else begin : g_zx
        assign b = {1'b0, in_data[2*i+1]};
      end
    end else begin : g_odd
      // Leftover term passes through unchanged (added to zero).
      assign b = '0;
    end

    assign sum[i] = a + b;
  end

  // Level register: data only moves on a real transfer, so it holds under stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= sum;
    end
  end
endmodule

// File: rtl/pipelined_adder.sv
// Pipelined adder tree: LEVELS chained stages, one register per level,
// valid/ready handshake on both sides with a combinational ready chain.
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int NUMBERS_AMOUNT = 8,
  parameter int NUMBER_WIDTH   = 4,
  parameter bit SIGNED         = 1'b0
) (
  input logic               clk_i,
  input logic               rst_i,
  pipelined_adder_if.slave  bus
);
  localparam int LEVELS = $clog2(NUMBERS_AMOUNT);

  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    localparam int TI = terms_at_level(NUMBERS_AMOUNT, k);
    localparam int TO = terms_at_level(NUMBERS_AMOUNT, k + 1);
    localparam int WI = NUMBER_WIDTH + k;

    logic [TI-1:0][WI-1:0] d_in;
    logic                  v_in;
    logic                  r_in;
    logic [TO-1:0][WI:0]   d_out;
    logic                  v_out;
    logic                  r_out;

    if (k == 0) begin : g_head
      assign d_in = bus.data_i;
      assign v_in = bus.data_valid_i;
    end else begin : g_link
      assign d_in = g_lvl[k-1].d_out;
      assign v_in = g_lvl[k-1].v_out;
    end

    // Ready flows backwards: the last level listens to the consumer.
    if (k == LEVELS - 1) begin : g_tail
      assign r_out = bus.ready_i;
    end else begin : g_mid
      assign r_out = g_lvl[k+1].r_in;
    end

    pipelined_adder_stage #(
      .IN_TERMS (TI),
      .IN_WIDTH (WI),
      .SIGNED   (SIGNED)
    ) u_stage (
      .clk       (clk_i),
      .rst       (rst_i),
      .in_data   (d_in),
      .in_valid  (v_in),
      .in_ready  (r_in),
      .out_data  (d_out),
      .out_valid (v_out),
      .out_ready (r_out)
    );
  end

  assign bus.ready_o      = g_lvl[0].r_in;
  assign bus.data_valid_o = g_lvl[LEVELS-1].v_out;
  assign bus.data_o       = g_lvl[LEVELS-1].d_out[0];
endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: signed 8x4 (main), unsigned 8x4, signed 5x4.
module tb_pipelined_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  typedef logic [7:0][3:0] vec8_t;
  typedef struct {
    vec8_t ops;
    int    exp;
  } vec_t;

  pipelined_adder_if #(.NUMBERS_AMOUNT(8), .NUMBER_WIDTH(4)) s8_if ();
  pipelined_adder_if #(.NUMBERS_AMOUNT(8), .NUMBER_WIDTH(4)) u8_if ();
  pipelined_adder_if #(.NUMBERS_AMOUNT(5), .NUMBER_WIDTH(4)) s5_if ();

  pipelined_adder #(.NUMBERS_AMOUNT(8), .NUMBER_WIDTH(4), .SIGNED(1'b1)) dut_s8 (
    .clk_i(clk), .rst_i(rst), .bus(s8_if));
  pipelined_adder #(.NUMBERS_AMOUNT(8), .NUMBER_WIDTH(4), .SIGNED(1'b0)) dut_u8 (
    .clk_i(clk), .rst_i(rst), .bus(u8_if));
  pipelined_adder #(.NUMBERS_AMOUNT(5), .NUMBER_WIDTH(4), .SIGNED(1'b1)) dut_s5 (
    .clk_i(clk), .rst_i(rst), .bus(s5_if));

  int tests = 0;
  int fails = 0;
  int recv = 0;
  int rdy_mode = 0;  // 0: ready_i=1, 1: random, 2: ready_i=0
  int q[$];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input string what);
    tests++;
    fails++;
    $display("FAIL %s: %s", name, what);
  endtask

  function automatic int ref_s8(input vec8_t v);
    int s = 0;
    for (int i = 0; i < 8; i++) s += int'($signed(v[i]));
    return s;
  endfunction

  // Downstream ready driver for the main DUT.
  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      1:       s8_if.ready_i = 1'($urandom_range(0, 1));
      2:       s8_if.ready_i = 1'b0;
      default: s8_if.ready_i = 1'b1;
    endcase
  end

  // Scoreboard / protocol monitor for the main DUT, sampled mid-cycle.
  initial begin : mon
    bit         prev_stall;
    logic [6:0] prev_data;
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        q.delete();
        prev_stall = 1'b0;
      end else begin
        check("ready_o_rule", int'(s8_if.ready_o),
              int'(!(!s8_if.ready_i && q.size() == 3)));
        if (prev_stall) begin
          check("hold_valid", int'(s8_if.data_valid_o), 1);
          check("hold_data", int'(s8_if.data_o), int'(prev_data));
        end
        if (s8_if.data_valid_o && s8_if.ready_i) begin
          recv++;
          if (q.size() == 0)
            flag("unexpected_out", $sformatf("got %0d, expected no result",
                 int'($signed(s8_if.data_o))));
          else
            check("sum_order", int'($signed(s8_if.data_o)), q.pop_front());
        end
        if (s8_if.data_valid_i && s8_if.ready_o) q.push_back(ref_s8(s8_if.data_i));
        prev_stall = s8_if.data_valid_o && !s8_if.ready_i;
        prev_data  = s8_if.data_o;
      end
    end
  end

  // Present v until accepted; tries = cycles spent. Ends at posedge+1.
  task automatic drive_s8(input vec8_t v, output int tries);
    bit acc;
    acc   = 1'b0;
    tries = 0;
    s8_if.data_i       = v;
    s8_if.data_valid_i = 1'b1;
    while (!acc && tries < 100) begin
      @(negedge clk);
      acc = s8_if.ready_o;
      tries++;
      @(posedge clk);
      #1;
    end
    s8_if.data_valid_i = 1'b0;
    if (!acc) flag("accept_timeout", "input never accepted within 100 cycles");
  endtask

  // Edges from acceptance until data_valid_o (ready_i held 1).
  task automatic wait_out_s8(output int lat, output int val);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!s8_if.data_valid_o && lat < 20);
    val = int'($signed(s8_if.data_o));
    if (!s8_if.data_valid_o) flag("out_timeout", "no data_valid_o within 20 cycles");
    @(posedge clk);
    #1;
  endtask

  // Single-vector test on the unsigned (id 0) or 5-operand (id 1) DUT.
  task automatic run_other(input int id, input vec8_t v, input int exp);
    bit acc;
    int lat, val, tries;
    if (id == 0) begin
      u8_if.data_i = v; u8_if.data_valid_i = 1'b1;
    end else begin
      s5_if.data_i = v[4:0]; s5_if.data_valid_i = 1'b1;
    end
    acc = 1'b0;
    tries = 0;
    while (!acc && tries < 100) begin
      @(negedge clk);
      acc = (id == 0) ? u8_if.ready_o : s5_if.ready_o;
      tries++;
      @(posedge clk);
      #1;
    end
    u8_if.data_valid_i = 1'b0;
    s5_if.data_valid_i = 1'b0;
    if (!acc) flag($sformatf("dut%0d_accept", id), "input never accepted");
    lat = 0;
    acc = 1'b0;
    while (!acc && lat < 20) begin
      @(negedge clk);
      lat++;
      acc = (id == 0) ? u8_if.data_valid_o : s5_if.data_valid_o;
    end
    val = (id == 0) ? int'(u8_if.data_o) : int'($signed(s5_if.data_o));
    check($sformatf("dut%0d_latency", id), lat, 3);
    check($sformatf("dut%0d_sum", id), val, exp);
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    vec_t  tbl[6];
    vec8_t v;
    int    lat, val, tries, base;

    s8_if.data_i = '0; s8_if.data_valid_i = 1'b0; s8_if.ready_i = 1'b1;
    u8_if.data_i = '0; u8_if.data_valid_i = 1'b0; u8_if.ready_i = 1'b1;
    s5_if.data_i = '0; s5_if.data_valid_i = 1'b0; s5_if.ready_i = 1'b1;

    tbl[0] = '{ops: {8{4'h8}}, exp: -64};
    tbl[1] = '{ops: {8{4'h7}}, exp: 56};
    tbl[2] = '{ops: {4'h8, 4'h7, 4'hF, 4'h0, 4'h3, 4'hC, 4'h5, 4'hE}, exp: 0};
    tbl[3] = '{ops: {8{4'hF}}, exp: -8};
    tbl[4] = '{ops: {4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8}, exp: 20};
    tbl[5] = '{ops: {4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h9}, exp: -7};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_data_o", int'(s8_if.data_o), 0);
    check("rst_valid_o", int'(s8_if.data_valid_o), 0);
    check("rst_ready_o", int'(s8_if.ready_o), 1);
    check("rst_u8_valid_o", int'(u8_if.data_valid_o), 0);
    check("rst_s5_valid_o", int'(s5_if.data_valid_o), 0);
    rst = 1'b0;

    // Directed table: latency and value, one vector at a time
    for (int i = 0; i < 6; i++) begin
      drive_s8(tbl[i].ops, tries);
      wait_out_s8(lat, val);
      check($sformatf("tbl%0d_latency", i), lat, 3);
      check($sformatf("tbl%0d_sum", i), val, tbl[i].exp);
    end

    // Ten back-to-back random vectors, full throughput
    base = recv;
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < 8; j++) v[j] = 4'($urandom_range(0, 15));
      drive_s8(v, tries);
      check($sformatf("b2b%0d_tries", i), tries, 1);
    end
    for (int c = 0; c < 50 && recv < base + 10; c++) @(posedge clk);
    #1;
    check("b2b_count", recv - base, 10);

    // Hold ready_i low: pipe fills, then ready_o drops
    rdy_mode = 2;
    repeat (2) @(posedge clk);
    #1;
    base = recv;
    for (int i = 0; i < 3; i++) drive_s8(tbl[i].ops, tries);
    s8_if.data_i = tbl[3].ops;
    s8_if.data_valid_i = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("full_ready_o", int'(s8_if.ready_o), 0);
      check("full_valid_o", int'(s8_if.data_valid_o), 1);
    end
    @(posedge clk);
    #1;
    rdy_mode = 0;
    drive_s8(tbl[3].ops, tries);
    for (int c = 0; c < 50 && recv < base + 4; c++) @(posedge clk);
    #1;
    check("full_drain_count", recv - base, 4);

    // Random back-pressure with ten random vectors
    rdy_mode = 1;
    base = recv;
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < 8; j++) v[j] = 4'($urandom_range(0, 15));
      drive_s8(v, tries);
    end
    rdy_mode = 0;
    for (int c = 0; c < 100 && recv < base + 10; c++) @(posedge clk);
    #1;
    check("stall_count", recv - base, 10);
    check("stall_queue_empty", q.size(), 0);

    // Reset with three vectors in flight
    for (int i = 0; i < 3; i++) drive_s8(tbl[i].ops, tries);
    rst = 1'b1;
    #1;
    check("midrst_valid_o", int'(s8_if.data_valid_o), 0);
    check("midrst_ready_o", int'(s8_if.ready_o), 1);
    check("midrst_data_o", int'(s8_if.data_o), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    base = recv;
    drive_s8(tbl[4].ops, tries);
    check("post_rst_tries", tries, 1);
    wait_out_s8(lat, val);
    check("post_rst_latency", lat, 3);
    check("post_rst_sum", val, 20);
    repeat (5) @(posedge clk);
    #1;
    check("post_rst_outputs", recv - base, 1);

    // Unsigned and non-power-of-two configurations
    run_other(0, {8{4'hF}}, 120);
    run_other(0, {4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1}, 16);
    run_other(1, {8{4'h7}}, 35);
    run_other(1, {8{4'h8}}, -40);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

Parameterised pipelined adder tree: sums `NUMBERS_AMOUNT` operands of `NUMBER_WIDTH` bits, signed or unsigned, in one registered adder level per tree stage. It uses a valid/ready stream handshake on both sides, so it can sit between any two streaming blocks in the math datapath. It accepts one operand vector per cycle when the downstream is ready, and it stalls cleanly under back-pressure without dropping or duplicating results.

## Interface
- `NUMBERS_AMOUNT`, default 8: number of operands; must be ≥ 2, need not be a power of two.
- `NUMBER_WIDTH`, default 4: width of each operand.
- `SIGNED`, default 0: 1 means operands and result are two's complement, 0 means unsigned.
- Derived `LEVELS = $clog2(NUMBERS_AMOUNT)`, `OUT_WIDTH = NUMBER_WIDTH + LEVELS`.
- `clk_i` in, 1 bit: the single clock; all logic is clocked on its rising edge.
- `rst_i` in, 1 bit: reset, asynchronous and active-high.
- `data_i` in, `[NUMBERS_AMOUNT-1:0][NUMBER_WIDTH-1:0]`: packed operand vector.
- `data_valid_i` in, 1 bit: `data_i` is valid.
- `ready_o` out, 1 bit: the block accepts `data_i` this cycle.
- `data_o` out, `OUT_WIDTH` bits: the sum.
- `data_valid_o` out, 1 bit: `data_o` is valid.
- `ready_i` in, 1 bit: downstream accepts `data_o`.

## Operation
- Level 0 takes the input operands. Level k pairs adjacent terms (2i, 2i+1) and registers their sums.
- An odd leftover term is registered unchanged into the next level.
- Each level grows the term width by 1 bit: sign-extended when `SIGNED=1`, zero-extended otherwise.
- The final level holds a single term, which drives `data_o`.
- The result is exact with no overflow. Example: 8×(−8) = −64 and 8×7 = 56, both fitting in 7 bits signed.
- Each level has one valid flag.
- Level k loads when `!valid_k || ready_(k+1)`; for the last level, `ready_(k+1)` is `ready_i`.
- `ready_o = !valid_0 || ready_1`, a combinational chain from `ready_i`.
- A transfer occurs on a cycle where valid and ready are both high, on either side.
- Results leave in input order.
- While `data_valid_o=1` and `ready_i=0`, `data_o` stays stable.
- Reset clears all valid flags and all data registers to 0, so `data_o=0`, `data_valid_o=0` and `ready_o=1`.
- Assertion of `rst_i` mid-stream discards all in-flight sums.

## Timing
- Latency: a vector accepted at edge t appears with `data_valid_o=1` after edge t+`LEVELS`−1 when there is no stall. That is `LEVELS` register stages; 3 for N=8.
- Throughput: one vector per cycle while `ready_i=1`.
- Back-pressure fills bubbles first. `ready_o` deasserts only when every level holds valid data and `ready_i=0`.
- When `ready_i` returns to 1, the whole pipe advances in the same cycle and `ready_o` rises combinationally.
- `data_valid_i` with `ready_o=0`: the upstream must hold `data_i` and `data_valid_i` until it sees `ready_o=1`.
- Release of `rst_i`: the pipe accepts input on the first rising edge after release.

## Structure
- Package `pipelined_adder_pkg` holds functions `out_width(amount, width)` and `terms_at_level(amount, k)`, computed as ceil(amount/2^k).
- One sub-module is natural: `pipelined_adder_stage`. It holds one tree level: parameters IN_TERMS, IN_WIDTH and SIGNED; pairwise adders; the odd-term pass-through; and the valid register with its ready logic.
- The top generates `LEVELS` stages in a chain.

## Test plan
- Signed N=8, W=4, `ready_i` held 1. Send all operands −8 → `data_o` = −64 (7'b1000000), 3 cycles after acceptance. Send all operands 7 → 56.
- Signed mix {−8,7,−1,0,3,−4,5,−2} → 0. Ten back-to-back random vectors → ten results in order, each equal to the reference sum.
- Unsigned (`SIGNED=0`), all operands 15 → 120.
- `ready_i` randomised at 50% with ten random vectors. Required response:
  - no result lost or duplicated, and order preserved;
  - `data_o` stable while stalled;
  - `ready_o` low only when the pipe is full and `ready_i=0`.
- N=5 (non-power of 2), signed, {7,7,7,7,7} → 35, out width 7, latency 3.
- Assert `rst_i` with 3 vectors in flight → `data_valid_o=0` immediately, `ready_o=1`. Stale sums never appear. The next vector after release produces its correct sum.
